sram_read_sched: RTL and testbench
==================================

Name: sram_read_sched

Overview:
Shares the single SRAM read port between the NUM_PORTS per-egress memory read controllers and tracks which port owns each in-flight read. It routes returned read data back to the correct port. It also serialises the per-port block free requests into the single free-list free port. It sits between the egress read controllers, the sram instance and the fl instance, all on switch_clk.

Parameters:
NUM_PORTS, 4, number of requesting egress ports (>=2)
ADDR_W, 10, SRAM block address / free-list index width
BLOCK_BITS, 256, SRAM data word width
RD_LAT, 1, cycles from mem_re_o high to mem_rvalid_i high (>=1, fixed)
MAX_BURST, 4, max consecutive read grants to one port before rotation (>=1)

Ports:
switch_clk  in  1  clock
switch_rst  in  1  synchronous, active-high reset
rd_req_i  in  NUM_PORTS  per-port read request, level; held with address until granted
rd_addr_i  in  NUM_PORTS x ADDR_W  per-port read address
rd_gnt_o  out  NUM_PORTS  one-hot read grant, combinational, same cycle as accept
mem_re_o  out  1  registered SRAM read enable
mem_raddr_o  out  ADDR_W  registered SRAM read address
mem_rvalid_i  in  1  SRAM read data valid
mem_rdata_i  in  BLOCK_BITS  SRAM read data
rd_rvalid_o  out  NUM_PORTS  one-hot return valid to owning port
rd_rdata_o  out  BLOCK_BITS  return data, broadcast to all ports
free_req_i  in  NUM_PORTS  per-port free request, held until granted
free_block_idx_i  in  NUM_PORTS x ADDR_W  per-port block index to free
free_gnt_o  out  NUM_PORTS  one-hot free grant, combinational
free_req_o  out  1  registered free request to free list
free_block_idx_o  out  ADDR_W  registered block index to free list
err_o  out  1  sticky protocol error flag

Behaviour:
- Reset, synchronous and active-high: all outputs 0. Read rr pointer = 0, last-port = 0, burst_cnt = 0. Free rr pointer = 0. Tag pipeline cleared. err_o = 0.
- Read arbitration, each cycle:
  - If last-port L is requesting and 0 < burst_cnt < MAX_BURST, grant L and increment burst_cnt.
  - Otherwise grant the first requester scanning from L+1, wrapping modulo NUM_PORTS. Set L to the winner and burst_cnt = 1.
  - No requesters: no grant, burst_cnt = 0, L unchanged.
  - At most one rd_gnt_o bit is high per cycle.
- Issue: grant in cycle T gives mem_re_o = 1 and mem_raddr_o = the winner's address in T+1. Same cycle, a tag {valid, port} enters an RD_LAT-deep shift register. Back-to-back grants are allowed every cycle; throughput is 1 read/cycle.
- Return: in the cycle the tag leaves the pipe (T+1+RD_LAT):
  - Tag valid and mem_rvalid_i = 1: rd_rvalid_o[port] = 1, combinational. rd_rdata_o follows mem_rdata_i combinationally at all times.
  - Tag valid and mem_rvalid_i = 0: err_o set.
  - Tag invalid and mem_rvalid_i = 1: err_o set and the data is dropped (no rd_rvalid_o).
- err_o is sticky until reset.
- Reset mid-operation: in-flight tags are discarded. mem_rvalid_i during the first RD_LAT+1 cycles after reset deassertion is ignored and not flagged.
- Free arbitration is independent plain round-robin, one grant/cycle, pointer = granted port + 1 (mod NUM_PORTS).
  - Grant in T gives free_req_o = 1 and free_block_idx_o = that index in T+1.
  - The free list accepts every cycle; no back-pressure.
- Read and free arbitration may both grant in the same cycle, to the same or different ports.
- Pointer wrap: after granting port NUM_PORTS-1, the scan starts at port 0.

Test Plan:
1. Reset, then port 2 requests address 0x05A alone. Required: rd_gnt_o = 4'b0100 in cycle 0; mem_re_o/mem_raddr_o = 0x05A in cycle 1. SRAM returns 0xAB.. in cycle 2 (RD_LAT = 1), giving rd_rvalid_o = 4'b0100 with that data; err_o = 0.
2. All four ports request continuously, MAX_BURST = 4. Required grant sequence is P1×4, P2×4, P3×4, P0×4, repeating. One mem_re_o every cycle; each return lands on the matching port.
3. Port 0 requests 2 reads then drops its request while port 3 requests. Required: P0, P0, then P3 in the next cycle with no idle gap. Burst counter restarts at 1 for P3.
4. free_req_i = 4'b1011 with indices 0x010/0x011/–/0x013, held until granted. Required: free_gnt_o order P0, P1, P3. free_block_idx_o = 0x010, 0x011, 0x013 in consecutive cycles, each one cycle after its grant.
5. Inject mem_rvalid_i with no read outstanding, 5 cycles after reset. Required: no rd_rvalid_o and err_o = 1, staying high. Separately, suppress an expected rvalid; required: err_o = 1.
6. Assert switch_rst while 1 read is in flight and port 1 is requesting. Required: all outputs 0 the cycle after reset. The stale rvalid arriving 1 cycle after deassertion is ignored with err_o = 0. After deassertion the first grant goes to port 1, scanning from port 1 since L = 0.

Source files
------------

// File: rtl/sram_read_sched.sv
// rtl/sram_read_sched.sv - shared SRAM read port scheduler with burst round-robin, return routing and free-request serialiser
module sram_read_sched #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 256,
  parameter int RD_LAT     = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                              switch_clk,
  input  logic                              switch_rst,
  input  logic [NUM_PORTS-1:0]              rd_req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  rd_addr_i,
  output logic [NUM_PORTS-1:0]              rd_gnt_o,
  output logic                              mem_re_o,
  output logic [ADDR_W-1:0]                 mem_raddr_o,
  input  logic                              mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0]             mem_rdata_i,
  output logic [NUM_PORTS-1:0]              rd_rvalid_o,
  output logic [BLOCK_BITS-1:0]             rd_rdata_o,
  input  logic [NUM_PORTS-1:0]              free_req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  free_block_idx_i,
  output logic [NUM_PORTS-1:0]              free_gnt_o,
  output logic                              free_req_o,
  output logic [ADDR_W-1:0]                 free_block_idx_o,
  output logic                              err_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(RD_LAT + 2);
  localparam logic [PW:0]    NP    = (PW + 1)'(NUM_PORTS);
  localparam logic [PW-1:0]  LASTP = PW'(NUM_PORTS - 1);
  localparam logic [BW-1:0]  MB    = BW'(MAX_BURST);
  localparam logic [IW-1:0]  IGN   = IW'(RD_LAT + 1);

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LASTP) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after start; scanning high-to-low offset leaves the nearest one.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [PW-1:0] start);
    logic [PW-1:0] pick;
    logic [PW:0]   s;
    pick = start;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      s = {1'b0, start} + (PW + 1)'(i);
      if (s >= NP) s = s - NP;
      if (req[s[PW-1:0]]) pick = s[PW-1:0];
    end
    return pick;
  endfunction

  logic [PW-1:0] last_port, rd_win, free_ptr, free_win;
  logic [BW-1:0] burst_cnt;
  logic          rd_any, rd_hold, free_any;
  logic [RD_LAT:0] tag_v;
  logic [PW-1:0] tag_p [RD_LAT+1];
  logic [IW-1:0] ign_cnt;
  logic          ret_v;
  logic [PW-1:0] ret_p;

  assign ret_v      = tag_v[RD_LAT];
  assign ret_p      = tag_p[RD_LAT];
  assign rd_rdata_o = mem_rdata_i;

  always_comb begin
    rd_any      = |rd_req_i;
    rd_hold     = rd_req_i[last_port] && (burst_cnt != '0) && (burst_cnt < MB);
    rd_win      = rd_hold ? last_port : rr_pick(rd_req_i, wrap_inc(last_port));
    free_any    = |free_req_i;
    free_win    = rr_pick(free_req_i, free_ptr);
    rd_gnt_o    = '0;
    free_gnt_o  = '0;
    rd_rvalid_o = '0;
    if (!switch_rst) begin
      if (rd_any)                 rd_gnt_o[rd_win]   = 1'b1;
      if (free_any)               free_gnt_o[free_win] = 1'b1;
      if (ret_v && mem_rvalid_i)  rd_rvalid_o[ret_p] = 1'b1;
    end
  end

  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      last_port        <= '0;
      burst_cnt        <= '0;
      mem_re_o         <= 1'b0;
      mem_raddr_o      <= '0;
      tag_v            <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_p[k] <= '0;
      ign_cnt          <= IGN;
      err_o            <= 1'b0;
      free_ptr         <= '0;
      free_req_o       <= 1'b0;
      free_block_idx_o <= '0;
    end else begin
      mem_re_o <= rd_any;
      if (rd_any) begin
        mem_raddr_o <= rd_addr_i[rd_win];
        last_port   <= rd_win;
        burst_cnt   <= rd_hold ? burst_cnt + 1'b1 : BW'(1);
      end else begin
        burst_cnt <= '0;
      end
      tag_v    <= {tag_v[RD_LAT-1:0], rd_any};
      tag_p[0] <= rd_win;
      for (int k = 1; k <= RD_LAT; k++) tag_p[k] <= tag_p[k-1];
      // Returns that straddle a reset are neither routed nor flagged.
      if (ign_cnt != '0)               ign_cnt <= ign_cnt - 1'b1;
      else if (ret_v != mem_rvalid_i)  err_o   <= 1'b1;
      free_req_o <= free_any;
      if (free_any) begin
        free_block_idx_o <= free_block_idx_i[free_win];
        free_ptr         <= wrap_inc(free_win);
      end
    end
  end

endmodule

// File: tb/tb_sram_read_sched.sv
// tb/tb_sram_read_sched.sv - directed scoreboard bench for sram_read_sched
module tb_sram_read_sched;

  logic             switch_clk, switch_rst;
  logic [3:0]       rd_req_i;
  logic [3:0][9:0]  rd_addr_i;
  logic [3:0]       rd_gnt_o;
  logic             mem_re_o;
  logic [9:0]       mem_raddr_o;
  logic             mem_rvalid_i;
  logic [255:0]     mem_rdata_i;
  logic [3:0]       rd_rvalid_o;
  logic [255:0]     rd_rdata_o;
  logic [3:0]       free_req_i;
  logic [3:0][9:0]  free_block_idx_i;
  logic [3:0]       free_gnt_o;
  logic             free_req_o;
  logic [9:0]       free_block_idx_o;
  logic             err_o;

  sram_read_sched dut (
    .switch_clk(switch_clk), .switch_rst(switch_rst),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
    .free_req_i(free_req_i), .free_block_idx_i(free_block_idx_i), .free_gnt_o(free_gnt_o),
    .free_req_o(free_req_o), .free_block_idx_o(free_block_idx_o), .err_o(err_o)
  );

  initial switch_clk = 1'b0;
  always #5 switch_clk = ~switch_clk;

  typedef struct packed { logic [1:0] port; logic [9:0] addr; } rd_t;
  rd_t        iss_q[$];
  rd_t        ret_q[$];
  logic [9:0] fq[$];
  logic       exp_err;
  int         checks = 0;
  int         passed = 0;

  function automatic logic [255:0] data_of(input logic [9:0] a);
    return {32{8'hAB}} ^ {246'd0, a};
  endfunction

  function automatic logic [1:0] port_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // SRAM model: data returns RD_LAT=1 cycle after the DUT's read enable.
  task automatic cycle();
    logic       m_re;
    logic [9:0] m_addr;
    m_re   = (mem_re_o === 1'b1);
    m_addr = mem_raddr_o;
    @(posedge switch_clk); #1;
    mem_rvalid_i = m_re;
    mem_rdata_i  = data_of(m_addr);
  endtask

  task automatic step(input logic [3:0] eg, input logic [3:0] efg);
    rd_t        e;
    logic [3:0] exp_rv;
    #1;
    chk("rd_gnt", rd_gnt_o, eg);
    chk("free_gnt", free_gnt_o, efg);
    chk("err", err_o, exp_err);
    exp_rv = 4'b0;
    if (ret_q.size() != 0) begin
      e = ret_q.pop_front();
      if (mem_rvalid_i) begin
        exp_rv = 4'b1 << e.port;
        chk("rd_rdata", rd_rdata_o, data_of(e.addr));
      end
    end
    chk("rd_rvalid", rd_rvalid_o, exp_rv);
    if (iss_q.size() != 0) begin
      e = iss_q.pop_front();
      chk("mem_re", mem_re_o, 1);
      chk("mem_raddr", mem_raddr_o, e.addr);
      ret_q.push_back(e);
    end else begin
      chk("mem_re_idle", mem_re_o, 0);
    end
    if (fq.size() != 0) begin
      chk("free_req", free_req_o, 1);
      chk("free_idx", free_block_idx_o, fq.pop_front());
    end else begin
      chk("free_req_idle", free_req_o, 0);
    end
    if (eg != 4'b0) begin
      e.port = port_of(eg);
      e.addr = rd_addr_i[e.port];
      iss_q.push_back(e);
    end
    if (efg != 4'b0) fq.push_back(free_block_idx_i[port_of(efg)]);
    cycle();
  endtask

  task automatic clear_sb();
    iss_q.delete();
    ret_q.delete();
    fq.delete();
    exp_err = 1'b0;
  endtask

  task automatic do_reset();
    switch_rst = 1'b1;
    rd_req_i   = 4'b0;
    free_req_i = 4'b0;
    clear_sb();
    cycle();
    chk("rst_raddr", mem_raddr_o, 0);
    chk("rst_free_idx", free_block_idx_o, 0);
    step(4'b0, 4'b0);
    switch_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    switch_rst = 1'b1;
    rd_req_i = 4'b0;
    rd_addr_i = '0;
    free_req_i = 4'b0;
    free_block_idx_i = '0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    exp_err = 1'b0;

    // Single read from port 2
    do_reset();
    rd_addr_i[2] = 10'h05A;
    rd_req_i = 4'b0100;
    step(4'b0100, 4'b0);
    rd_req_i = 4'b0;
    repeat (3) step(4'b0, 4'b0);

    // All ports requesting: bursts of MAX_BURST rotating from port 1
    do_reset();
    for (int i = 0; i < 4; i++) rd_addr_i[i] = 10'h100 + 10'(i);
    rd_req_i = 4'b1111;
    for (int k = 0; k < 20; k++) step(4'b1 << ((1 + k / 4) % 4), 4'b0);
    rd_req_i = 4'b0;
    repeat (3) step(4'b0, 4'b0);

    // Port 0 burst cut short, port 3 takes over and gets a fresh full burst
    rd_req_i = 4'b0001; step(4'b0001, 4'b0);
    rd_req_i = 4'b1001; step(4'b0001, 4'b0);
    rd_req_i = 4'b1000; step(4'b1000, 4'b0);
    step(4'b1000, 4'b0);
    rd_req_i = 4'b1001; step(4'b1000, 4'b0);
    step(4'b1000, 4'b0);
    step(4'b0001, 4'b0);
    rd_req_i = 4'b0;
    repeat (3) step(4'b0, 4'b0);

    // Free serialisation alongside a concurrent read grant
    free_block_idx_i[0] = 10'h010;
    free_block_idx_i[1] = 10'h011;
    free_block_idx_i[2] = 10'h3FF;
    free_block_idx_i[3] = 10'h013;
    free_req_i = 4'b1011;
    rd_req_i = 4'b0001;
    step(4'b0001, 4'b0001);
    rd_req_i = 4'b0;
    free_req_i = 4'b1010; step(4'b0, 4'b0010);
    free_req_i = 4'b1000; step(4'b0, 4'b1000);
    free_req_i = 4'b0;
    repeat (3) step(4'b0, 4'b0);

    // Unsolicited return data, 5 cycles after reset
    do_reset();
    repeat (5) step(4'b0, 4'b0);
    mem_rvalid_i = 1'b1;
    step(4'b0, 4'b0);
    exp_err = 1'b1;
    repeat (3) step(4'b0, 4'b0);

    // Expected return never arrives
    do_reset();
    rd_addr_i[0] = 10'h033;
    rd_req_i = 4'b0001;
    step(4'b0001, 4'b0);
    rd_req_i = 4'b0;
    step(4'b0, 4'b0);
    mem_rvalid_i = 1'b0;
    step(4'b0, 4'b0);
    exp_err = 1'b1;
    repeat (2) step(4'b0, 4'b0);

    // Reset with a read in flight and port 1 waiting
    do_reset();
    rd_addr_i[0] = 10'h100;
    rd_addr_i[1] = 10'h101;
    rd_req_i = 4'b0001;
    step(4'b0001, 4'b0);
    rd_req_i = 4'b0010;
    switch_rst = 1'b1;
    step(4'b0, 4'b0);
    clear_sb();
    chk("rst6_raddr", mem_raddr_o, 0);
    chk("rst6_free_idx", free_block_idx_o, 0);
    step(4'b0, 4'b0);
    switch_rst = 1'b0;
    step(4'b0010, 4'b0);
    rd_req_i = 4'b0;
    mem_rvalid_i = 1'b1;
    step(4'b0, 4'b0);
    repeat (2) step(4'b0, 4'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
